// File: rtl/uart_pkg.sv
// Shared UART constants: parity modes, transmit FSM state codes and MIDI baud rate.
// Used by the transmit path and the receive path.
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  localparam int unsigned MIDI_BAUD = 31250;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Word handshake plus serial/status outputs of one buffered UART transmitter.
// The master pushes words; the slave is the transmitter.
interface uart_tx_fifo_if #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  logic                 tx_valid;
  logic                 tx_ready;
  logic [DATA_BITS-1:0] data;
  logic                 tx;
  logic                 busy;
  logic [LW-1:0]        fifo_level;

  modport master (output tx_valid, data, input tx_ready, tx, busy, fifo_level);
  modport slave  (input tx_valid, data, output tx_ready, tx, busy, fifo_level);
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with occupancy count; head word is visible combinationally.
// Push when full and pop when empty are ignored.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata_c,
  output logic                     full_c,
  output logic                     empty_c,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full_c  = (level == LW'(DEPTH));
  assign empty_c = (level == '0);
  assign rdata_c = mem[rd_ptr];
  assign do_push = push & ~full_c;
  assign do_pop  = pop & ~empty_c;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end
endmodule

// File: rtl/uart_tx_fifo.sv
// FIFO-buffered UART transmitter: start / LSB-first data / optional parity / stop bits,
// queued frames sent back-to-back.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 32,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = PARITY_NONE,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_fifo_if.slave   bus
);
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(DATA_BITS);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_fifo: CLKS_PER_BIT must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_db
    $error("uart_tx_fifo: DATA_BITS must be 5..9");
  end
  if (PARITY > PARITY_ODD) begin : g_bad_par
    $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_sb
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
  end

  logic [2:0]           state, state_n;
  logic [CW-1:0]        baud_cnt, baud_n;
  logic [BW-1:0]        bit_cnt, bit_n;
  logic [DATA_BITS-1:0] sr, sr_n;
  logic                 par_bit, par_n;
  logic                 tx_q, tx_n;
  logic                 ready_en;
  logic                 bit_end;
  logic                 push, pop;
  logic [DATA_BITS-1:0] head;
  logic                 head_par;
  logic                 full_c, empty_c;
  logic [LW-1:0]        level;

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wdata   (bus.data),
    .rdata_c (head),
    .full_c  (full_c),
    .empty_c (empty_c),
    .level   (level)
  );

  // Ready comes only from registered state: held low through reset, no pop-to-ready path.
  assign bus.tx_ready   = ready_en & ~full_c;
  assign push           = bus.tx_valid & bus.tx_ready;
  assign bus.tx         = tx_q;
  assign bus.busy       = (state != ST_IDLE) | ~empty_c;
  assign bus.fifo_level = level;

  assign bit_end  = (baud_cnt == CW'(CLKS_PER_BIT - 1));
  assign head_par = (PARITY == PARITY_ODD) ? ~^head : ^head;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      sr       <= '0;
      par_bit  <= 1'b0;
      tx_q     <= 1'b1;
      ready_en <= 1'b0;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_cnt  <= bit_n;
      sr       <= sr_n;
      par_bit  <= par_n;
      tx_q     <= tx_n;
      ready_en <= 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    baud_n  = bit_end ? '0 : baud_cnt + CW'(1);
    bit_n   = bit_cnt;
    sr_n    = sr;
    par_n   = par_bit;
    tx_n    = tx_q;
    pop     = 1'b0;
    case (state)
      ST_IDLE: begin
        baud_n = '0;
        bit_n  = '0;
        tx_n   = 1'b1;
        if (!empty_c) begin
          pop     = 1'b1;
          sr_n    = head;
          par_n   = head_par;
          tx_n    = 1'b0;
          state_n = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          tx_n    = sr[0];
          state_n = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          sr_n = sr >> 1;
          if (bit_cnt == BW'(DATA_BITS - 1)) begin
            bit_n = '0;
            if (PARITY != PARITY_NONE) begin
              tx_n    = par_bit;
              state_n = ST_PARITY;
            end else begin
              tx_n    = 1'b1;
              state_n = ST_STOP;
            end
          end else begin
            bit_n = bit_cnt + BW'(1);
            tx_n  = sr[1];
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          tx_n    = 1'b1;
          state_n = ST_STOP;
        end
      end
      ST_STOP: begin
        // Chain straight into the next queued frame with no idle cycle.
        if (bit_end) begin
          if (bit_cnt == BW'(STOP_BITS - 1)) begin
            bit_n = '0;
            if (!empty_c) begin
              pop     = 1'b1;
              sr_n    = head;
              par_n   = head_par;
              tx_n    = 1'b0;
              state_n = ST_START;
            end else begin
              tx_n    = 1'b1;
              state_n = ST_IDLE;
            end
          end else begin
            bit_n = bit_cnt + BW'(1);
          end
        end
      end
      default: begin
        tx_n    = 1'b1;
        state_n = ST_IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised and directed bench for uart_tx_fifo over four parameter sets,
// compared against a frame-level queue model.
module tb_uart_tx_fifo;
  localparam int NDUT = 4;
  localparam int CPB [NDUT] = '{4, 4, 4, 3};
  localparam int DB  [NDUT] = '{8, 8, 8, 7};
  localparam int PAR [NDUT] = '{0, 1, 0, 2};
  localparam int SB  [NDUT] = '{1, 1, 2, 1};
  localparam int DEP [NDUT] = '{4, 4, 4, 8};

  logic       clk;
  logic       rst;
  logic       vld [NDUT];
  logic [8:0] din [NDUT];
  logic       obs_tx [NDUT];
  logic       obs_ready [NDUT];
  logic       obs_busy [NDUT];
  logic [3:0] obs_level [NDUT];

  int ncmp;
  int nbad;

  // Frame-level model: queue of words plus the bit pattern of the frame on the line.
  logic [8:0] mq [NDUT][$];
  bit         act  [NDUT];
  int         pos  [NDUT];
  bit         en   [NDUT];
  bit         acc  [NDUT];
  bit         fbit [NDUT][16];
  int         flen [NDUT];

  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) ifa ();
  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) ifb ();
  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) ifc ();
  uart_tx_fifo_if #(.DATA_BITS(7), .FIFO_DEPTH(8)) ifd ();

  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));
  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));
  uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4))
    dut_c (.clk(clk), .rst(rst), .bus(ifc));
  uart_tx_fifo #(.CLKS_PER_BIT(3), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(8))
    dut_d (.clk(clk), .rst(rst), .bus(ifd));

  assign ifa.tx_valid = vld[0];
  assign ifb.tx_valid = vld[1];
  assign ifc.tx_valid = vld[2];
  assign ifd.tx_valid = vld[3];
  assign ifa.data = din[0][7:0];
  assign ifb.data = din[1][7:0];
  assign ifc.data = din[2][7:0];
  assign ifd.data = din[3][6:0];
  assign obs_tx[0] = ifa.tx;
  assign obs_tx[1] = ifb.tx;
  assign obs_tx[2] = ifc.tx;
  assign obs_tx[3] = ifd.tx;
  assign obs_ready[0] = ifa.tx_ready;
  assign obs_ready[1] = ifb.tx_ready;
  assign obs_ready[2] = ifc.tx_ready;
  assign obs_ready[3] = ifd.tx_ready;
  assign obs_busy[0] = ifa.busy;
  assign obs_busy[1] = ifb.busy;
  assign obs_busy[2] = ifc.busy;
  assign obs_busy[3] = ifd.busy;
  assign obs_level[0] = {1'b0, ifa.fifo_level};
  assign obs_level[1] = {1'b0, ifb.fifo_level};
  assign obs_level[2] = {1'b0, ifc.fifo_level};
  assign obs_level[3] = ifd.fifo_level;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] msk(input int d, input logic [8:0] w);
    return w & 9'((1 << DB[d]) - 1);
  endfunction

  function automatic void load_frame(input int d, input logic [8:0] w);
    int n;
    n = 0;
    fbit[d][n] = 1'b0; n++;
    for (int i = 0; i < DB[d]; i++) begin fbit[d][n] = w[i]; n++; end
    if (PAR[d] != 0) begin
      fbit[d][n] = (PAR[d] == 1) ? ($countones(w) % 2 == 1) : ($countones(w) % 2 == 0);
      n++;
    end
    for (int i = 0; i < SB[d]; i++) begin fbit[d][n] = 1'b1; n++; end
    flen[d] = n * CPB[d];
  endfunction

  function automatic logic exp_tx(input int d);
    return act[d] ? fbit[d][pos[d] / CPB[d]] : 1'b1;
  endfunction

  function automatic logic exp_busy(input int d);
    return act[d] || (mq[d].size() != 0);
  endfunction

  // One clock edge: advance the model with the inputs seen at that edge, then settle.
  task automatic step();
    logic [8:0] w;
    bit         can_pop;
    @(posedge clk);
    for (int d = 0; d < NDUT; d++) begin
      acc[d] = 1'b0;
      if (!rst) begin
        mq[d].delete();
        act[d] = 1'b0;
        pos[d] = 0;
        en[d]  = 1'b0;
      end else begin
        can_pop = (mq[d].size() != 0);
        acc[d]  = vld[d] && en[d] && (mq[d].size() < DEP[d]);
        if (act[d]) begin
          pos[d]++;
          if (pos[d] == flen[d]) act[d] = 1'b0;
        end
        if (!act[d] && can_pop) begin
          w = mq[d].pop_front();
          load_frame(d, w);
          act[d] = 1'b1;
          pos[d] = 0;
        end
        if (acc[d]) mq[d].push_back(msk(d, din[d]));
        en[d] = 1'b1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) step();
    for (int d = 0; d < NDUT; d++) begin
      ncmp++; if (obs_tx[d] !== 1'b1) begin nbad++; $display("FAIL reset_tx d=%0d got=%b want=1", d, obs_tx[d]); end
      ncmp++; if (obs_ready[d] !== 1'b0) begin nbad++; $display("FAIL reset_ready d=%0d got=%b want=0", d, obs_ready[d]); end
      ncmp++; if (obs_level[d] !== 4'd0) begin nbad++; $display("FAIL reset_level d=%0d got=%0d want=0", d, obs_level[d]); end
      ncmp++; if (obs_busy[d] !== 1'b0) begin nbad++; $display("FAIL reset_busy d=%0d got=%b want=0", d, obs_busy[d]); end
    end
    rst = 1'b1;
    step();
    for (int d = 0; d < NDUT; d++) begin
      ncmp++; if (obs_ready[d] !== 1'b1) begin nbad++; $display("FAIL release_ready d=%0d got=%b want=1", d, obs_ready[d]); end
    end
  endtask

  // Single frame into an idle transmitter, checked cycle-by-cycle and by mid-bit decode.
  task automatic test_frame(input int d, input logic [8:0] w, input int exp_par, input string nm);
    logic       smp [$];
    logic [8:0] m;
    logic       eb;
    int         nb, guard, idx;
    m = msk(d, w);
    vld[d] = 1'b1; din[d] = w;
    step();
    vld[d] = 1'b0;
    ncmp++; if (obs_tx[d] !== 1'b1) begin nbad++; $display("FAIL %s push_tx got=%b want=1", nm, obs_tx[d]); end
    ncmp++; if (obs_level[d] !== 4'd1) begin nbad++; $display("FAIL %s push_level got=%0d want=1", nm, obs_level[d]); end
    guard = 0;
    do begin
      step();
      guard++;
      ncmp++; if (obs_tx[d] !== exp_tx(d)) begin nbad++; $display("FAIL %s tx t=%0t got=%b want=%b", nm, $time, obs_tx[d], exp_tx(d)); end
      ncmp++; if (obs_busy[d] !== exp_busy(d)) begin nbad++; $display("FAIL %s busy t=%0t got=%b want=%b", nm, $time, obs_busy[d], exp_busy(d)); end
      if (obs_busy[d] === 1'b1) smp.push_back(obs_tx[d]);
    end while (exp_busy(d) && guard < 400);
    ncmp++; if (guard >= 400) begin nbad++; $display("FAIL %s timeout got=%0d want<400", nm, guard); end
    nb = 1 + DB[d] + ((PAR[d] != 0) ? 1 : 0) + SB[d];
    ncmp++; if (smp.size() != nb * CPB[d]) begin nbad++; $display("FAIL %s frame_len got=%0d want=%0d", nm, smp.size(), nb * CPB[d]); end
    ncmp++; if (smp.size() == 0 || smp[0] !== 1'b0) begin nbad++; $display("FAIL %s latency got=%0d samples want start low", nm, smp.size()); end
    for (int b = 0; b < nb; b++) begin
      if (b == 0) eb = 1'b0;
      else if (b <= DB[d]) eb = m[b-1];
      else if (PAR[d] != 0 && b == DB[d] + 1) eb = exp_par[0];
      else eb = 1'b1;
      idx = b * CPB[d] + CPB[d] / 2;
      if (idx < smp.size()) begin
        ncmp++; if (smp[idx] !== eb) begin nbad++; $display("FAIL %s bit%0d got=%b want=%b", nm, b, smp[idx], eb); end
      end
    end
  endtask

  // Hold valid with 1..6 on the 8N1 instance: backpressure, ordering and gapless chaining.
  task automatic test_back_to_back();
    logic       smp [$];
    logic [7:0] byte_got;
    int         sent, guard, full_seen;
    bit         started;
    sent = 0; guard = 0; full_seen = 0; started = 1'b0;
    vld[0] = 1'b1; din[0] = 9'd1;
    do begin
      step();
      guard++;
      if (acc[0]) begin
        sent++;
        din[0] = 9'(sent + 1);
        if (sent == 6) vld[0] = 1'b0;
      end
      ncmp++; if (obs_tx[0] !== exp_tx(0)) begin nbad++; $display("FAIL b2b tx t=%0t got=%b want=%b", $time, obs_tx[0], exp_tx(0)); end
      ncmp++; if (obs_level[0] !== 4'(mq[0].size())) begin nbad++; $display("FAIL b2b level t=%0t got=%0d want=%0d", $time, obs_level[0], mq[0].size()); end
      ncmp++; if (obs_ready[0] !== (mq[0].size() < 4)) begin nbad++; $display("FAIL b2b ready t=%0t got=%b want=%b", $time, obs_ready[0], mq[0].size() < 4); end
      if (obs_level[0] === 4'd4) begin
        full_seen++;
        ncmp++; if (obs_ready[0] !== 1'b0) begin nbad++; $display("FAIL b2b full_ready t=%0t got=%b want=0", $time, obs_ready[0]); end
      end
      if (obs_tx[0] === 1'b0) started = 1'b1;
      if (started && obs_busy[0] === 1'b1) smp.push_back(obs_tx[0]);
    end while ((sent < 6 || exp_busy(0)) && guard < 2000);
    ncmp++; if (guard >= 2000) begin nbad++; $display("FAIL b2b timeout got=%0d want<2000", guard); end
    ncmp++; if (full_seen == 0) begin nbad++; $display("FAIL b2b reached_full got=0 want>0"); end
    ncmp++; if (smp.size() != 240) begin nbad++; $display("FAIL b2b span got=%0d want=240", smp.size()); end
    for (int f = 0; f < 6; f++) begin
      byte_got = '0;
      for (int i = 0; i < 8; i++)
        if (f * 40 + (1 + i) * 4 + 2 < smp.size()) byte_got[i] = smp[f * 40 + (1 + i) * 4 + 2];
      ncmp++; if (byte_got !== 8'(f + 1)) begin nbad++; $display("FAIL b2b word%0d got=%02h want=%02h", f, byte_got, f + 1); end
    end
  endtask

  // Push landing exactly on the final stop-bit edge of the previous frame.
  task automatic test_edge_push();
    logic       smp [$];
    logic [7:0] byte_got;
    int         guard, n_idle;
    vld[0] = 1'b1; din[0] = 9'h055;
    step();
    vld[0] = 1'b0;
    guard = 0;
    while (!(act[0] && pos[0] == flen[0] - 1) && guard < 200) begin
      step();
      guard++;
      ncmp++; if (obs_tx[0] !== exp_tx(0)) begin nbad++; $display("FAIL edge tx t=%0t got=%b want=%b", $time, obs_tx[0], exp_tx(0)); end
    end
    ncmp++; if (guard >= 200) begin nbad++; $display("FAIL edge reach_stop got=%0d want<200", guard); end
    vld[0] = 1'b1; din[0] = 9'h055;
    step();
    vld[0] = 1'b0;
    ncmp++; if (obs_level[0] !== 4'd1) begin nbad++; $display("FAIL edge level got=%0d want=1", obs_level[0]); end
    n_idle = 0;
    while (obs_tx[0] !== 1'b0 && n_idle < 3) begin step(); n_idle++; end
    ncmp++; if (n_idle > 1) begin nbad++; $display("FAIL edge idle_gap got=%0d want<=1", n_idle); end
    guard = 0;
    while (obs_busy[0] === 1'b1 && guard < 100) begin
      smp.push_back(obs_tx[0]);
      step();
      guard++;
    end
    ncmp++; if (smp.size() != 40) begin nbad++; $display("FAIL edge frame_len got=%0d want=40", smp.size()); end
    byte_got = '0;
    for (int i = 0; i < 8; i++)
      if ((1 + i) * 4 + 2 < smp.size()) byte_got[i] = smp[(1 + i) * 4 + 2];
    ncmp++; if (byte_got !== 8'h55) begin nbad++; $display("FAIL edge word got=%02h want=55", byte_got); end
  endtask

  // Reset mid-data-bit of the second of three queued words.
  task automatic test_reset_mid();
    vld[0] = 1'b1;
    din[0] = 9'h011; step();
    din[0] = 9'h022; step();
    din[0] = 9'h033; step();
    vld[0] = 1'b0;
    repeat (52) step();
    ncmp++; if (!(act[0] && pos[0] >= 4 && pos[0] < 36)) begin nbad++; $display("FAIL rstmid in_data got=pos%0d want=4..35", pos[0]); end
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      ncmp++; if (obs_tx[0] !== 1'b1) begin nbad++; $display("FAIL rstmid tx c=%0d got=%b want=1", c, obs_tx[0]); end
      ncmp++; if (obs_level[0] !== 4'd0) begin nbad++; $display("FAIL rstmid level c=%0d got=%0d want=0", c, obs_level[0]); end
      ncmp++; if (obs_ready[0] !== 1'b0) begin nbad++; $display("FAIL rstmid ready c=%0d got=%b want=0", c, obs_ready[0]); end
    end
    rst = 1'b1;
    for (int c = 0; c < 100; c++) begin
      step();
      ncmp++; if (obs_tx[0] !== 1'b1 || obs_busy[0] !== 1'b0) begin nbad++; $display("FAIL rstmid after c=%0d got=tx%b/busy%b want=tx1/busy0", c, obs_tx[0], obs_busy[0]); end
    end
  endtask

  // Random traffic on every instance, all outputs against the model each cycle.
  task automatic test_random();
    int thr [NDUT];
    for (int c = 0; c < 3600; c++) begin
      if (c % 400 == 0)
        for (int d = 0; d < NDUT; d++) thr[d] = $urandom_range(5, 95);
      for (int d = 0; d < NDUT; d++) begin
        vld[d] = (c < 3000) && ($urandom_range(0, 99) < thr[d]);
        din[d] = 9'($urandom);
      end
      step();
      for (int d = 0; d < NDUT; d++) begin
        ncmp++; if (obs_tx[d] !== exp_tx(d)) begin nbad++; $display("FAIL rand tx d=%0d t=%0t got=%b want=%b", d, $time, obs_tx[d], exp_tx(d)); end
        ncmp++; if (obs_ready[d] !== (mq[d].size() < DEP[d])) begin nbad++; $display("FAIL rand ready d=%0d t=%0t got=%b want=%b", d, $time, obs_ready[d], mq[d].size() < DEP[d]); end
        ncmp++; if (obs_level[d] !== 4'(mq[d].size())) begin nbad++; $display("FAIL rand level d=%0d t=%0t got=%0d want=%0d", d, $time, obs_level[d], mq[d].size()); end
        ncmp++; if (obs_busy[d] !== exp_busy(d)) begin nbad++; $display("FAIL rand busy d=%0d t=%0t got=%b want=%b", d, $time, obs_busy[d], exp_busy(d)); end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t got=no finish want=finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    ncmp = 0;
    nbad = 0;
    rst  = 1'b0;
    for (int d = 0; d < NDUT; d++) begin vld[d] = 1'b0; din[d] = '0; end
    test_reset();
    test_frame(0, 9'h0A5, -1, "8n1_a5");
    test_frame(1, 9'h0A5, 0, "8e1_a5");
    test_frame(1, 9'h001, 1, "8e1_01");
    test_frame(2, 9'h000, -1, "8n2_00");
    test_frame(3, 9'h0A5, 0, "7o1_a5");
    test_frame(3, 9'h003, 1, "7o1_03");
    test_back_to_back();
    test_edge_push();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule
